// File: rtl/a5_burst_cipher_pkg.sv
// Shared types and constants for the A5 burst cipher consumer.
package a5_burst_cipher_pkg;

    localparam int unsigned KEY_BITS        = 64;
    localparam int unsigned FRAME_BITS      = 22;
    localparam int unsigned BURST_BITS_DEF  = 228;
    localparam int unsigned DATA_W_DEF      = 4;
    localparam int unsigned WORDS_PER_BURST = BURST_BITS_DEF / DATA_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARMUP,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/a5_ks_packer.sv
// Collects generator keystream bits LSB-first into a DATA_W-bit word.
module a5_ks_packer #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic              gen_q,
    output logic [DATA_W-1:0] ks_word,
    output logic              ks_full
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  ks_cnt_q, ks_cnt_d;
    logic [DATA_W-1:0] ks_word_q, ks_word_d;

    always_comb begin
        ks_cnt_d  = ks_cnt_q;
        ks_word_d = ks_word_q;
        if (clr) begin
            // Refill begins in the clearing cycle, so a capture lands in bit 0.
            ks_word_d    = '0;
            ks_word_d[0] = cap & gen_q;
            ks_cnt_d     = cap ? CNT_W'(1) : '0;
        end else if (cap) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (ks_cnt_q == CNT_W'(i)) begin
                    ks_word_d[i] = gen_q;
                end
            end
            if (ks_cnt_q != CNT_W'(DATA_W)) begin
                ks_cnt_d = ks_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_cnt_q  <= '0;
            ks_word_q <= '0;
        end else begin
            ks_cnt_q  <= ks_cnt_d;
            ks_word_q <= ks_word_d;
        end
    end

    assign ks_word = ks_word_q;
    assign ks_full = (ks_cnt_q == CNT_W'(DATA_W));

endmodule

// File: rtl/a5_burst_cipher.sv
// Drives an external A5 keystream generator and XORs its packed keystream
// onto a valid/ready word stream, one BURST_BITS burst per configuration.
module a5_burst_cipher
    import a5_burst_cipher_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned BURST_BITS = BURST_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [KEY_BITS-1:0]   cfg_key,
    input  logic [FRAME_BITS-1:0] cfg_frame,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  done,
    output logic                  gen_load,
    output logic                  gen_stall,
    output logic [KEY_BITS-1:0]   gen_key,
    output logic [FRAME_BITS-1:0] gen_frame,
    input  logic                  gen_q,
    input  logic                  gen_valid
);

    localparam int unsigned WORDS = BURST_BITS / DATA_W;
    localparam int unsigned WC_W  = $clog2(WORDS + 1);

    state_e                state_q, state_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [WC_W-1:0]       word_cnt_q, word_cnt_d;

    logic [DATA_W-1:0] ks_word;
    logic              ks_full;
    logic              accept, capture, abort_act, last_word, ks_clr;

    assign abort_act = abort && (state_q != ST_IDLE);
    assign last_word = (word_cnt_q == WC_W'(WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cfg_valid) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_WARMUP;
            ST_WARMUP: if (gen_valid) state_d = ST_RUN;
            ST_RUN:    if (accept && last_word) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_act) state_d = ST_IDLE;
    end

    // The generator only advances when a bit is captured, so stall covers
    // every cycle in which the packer could not take a new bit.
    always_comb begin
        cfg_ready = 1'b0;
        gen_load  = 1'b0;
        gen_stall = 1'b1;
        in_ready  = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE:   cfg_ready = 1'b1;
            ST_LOAD: begin
                gen_load  = 1'b1;
                gen_stall = 1'b0;
            end
            ST_WARMUP: gen_stall = 1'b0;
            ST_RUN: begin
                in_ready  = ks_full && (!out_valid_q || out_ready);
                accept    = in_valid && in_ready && !abort;
                gen_stall = (ks_full && !accept) || (last_word && accept);
            end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
        if (abort_act) begin
            gen_stall = 1'b1;
            done      = 1'b0;
        end
        capture = gen_valid && !gen_stall && (state_q == ST_WARMUP || state_q == ST_RUN);
        ks_clr  = (state_q == ST_LOAD) || accept;
    end

    always_comb begin
        key_d       = key_q;
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;
        if (state_q == ST_IDLE && cfg_valid) begin
            key_d   = cfg_key;
            frame_d = cfg_frame;
        end
        if (state_q == ST_LOAD) begin
            word_cnt_d = '0;
        end else if (accept && word_cnt_q != WC_W'(WORDS)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        if (abort_act) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ ks_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    a5_ks_packer #(.DATA_W(DATA_W)) u_packer (
        .clk     (clk),
        .rst     (reset),
        .clr     (ks_clr),
        .cap     (capture),
        .gen_q   (gen_q),
        .ks_word (ks_word),
        .ks_full (ks_full)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign gen_key   = key_q;
    assign gen_frame = frame_q;

endmodule

// File: tb/tb_a5_burst_cipher.sv
// Scoreboard bench for a5_burst_cipher with a behavioural A5/1 generator attached.
module tb_a5_burst_cipher;

    localparam int NW = 57;
    localparam logic [63:0] KEY   = 64'h12234567_89ABCDEF;
    localparam logic [21:0] FRAME = 22'h134;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [63:0] cfg_key = '0;
    logic [21:0] cfg_frame = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_data;
    logic        done;
    logic        gen_load;
    logic        gen_stall;
    logic [63:0] gen_key;
    logic [21:0] gen_frame;
    logic        gen_q;
    logic        gen_valid;

    always #5 clk = ~clk;

    a5_burst_cipher #(.DATA_W(4), .BURST_BITS(228)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_frame(cfg_frame),
        .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done),
        .gen_load(gen_load), .gen_stall(gen_stall), .gen_key(gen_key), .gen_frame(gen_frame),
        .gen_q(gen_q), .gen_valid(gen_valid)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [3:0]  exp_q[$];
    logic [227:0] golden = '0;

    // A5/1 reference: shift left, feedback parity into bit 0, output = MSB xor.
    function automatic logic [18:0] clk1(input logic [18:0] r);
        return {r[17:0], ^(r & 19'h72000)};
    endfunction
    function automatic logic [21:0] clk2(input logic [21:0] r);
        return {r[20:0], ^(r & 22'h300000)};
    endfunction
    function automatic logic [22:0] clk3(input logic [22:0] r);
        return {r[21:0], ^(r & 23'h700080)};
    endfunction

    function automatic logic [227:0] a5_stream(input logic [63:0] key, input logic [21:0] frame);
        logic [18:0]  r1 = '0;
        logic [21:0]  r2 = '0;
        logic [22:0]  r3 = '0;
        logic [227:0] ks = '0;
        logic         b, maj;
        for (int i = 0; i < 64; i++) begin
            b  = key[56 - 8 * (i / 8) + (i % 8)];
            r1 = clk1(r1); r2 = clk2(r2); r3 = clk3(r3);
            r1[0] = r1[0] ^ b; r2[0] = r2[0] ^ b; r3[0] = r3[0] ^ b;
        end
        for (int i = 0; i < 22; i++) begin
            b  = frame[i];
            r1 = clk1(r1); r2 = clk2(r2); r3 = clk3(r3);
            r1[0] = r1[0] ^ b; r2[0] = r2[0] ^ b; r3[0] = r3[0] ^ b;
        end
        for (int i = 0; i < 328; i++) begin
            maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
            if (r1[8] == maj)  r1 = clk1(r1);
            if (r2[10] == maj) r2 = clk2(r2);
            if (r3[10] == maj) r3 = clk3(r3);
            if (i >= 100) ks[i - 100] = r1[18] ^ r2[21] ^ r3[22];
        end
        return ks;
    endfunction

    // Behavioural generator: 3-cycle latency after load, advances one bit per unstalled valid cycle.
    logic [227:0] gen_ks = '0;
    int           gen_ptr = 0;
    int           gen_wait = 0;
    logic         gen_valid_r = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_valid_r <= 1'b0;
            gen_ptr     <= 0;
            gen_wait    <= 0;
        end else if (gen_load) begin
            gen_ks      <= a5_stream(gen_key, gen_frame);
            gen_ptr     <= 0;
            gen_valid_r <= 1'b0;
            gen_wait    <= 3;
        end else if (!gen_valid_r) begin
            if (gen_wait > 0) begin
                if (gen_wait == 1) gen_valid_r <= 1'b1;
                gen_wait <= gen_wait - 1;
            end
        end else if (!gen_stall) begin
            gen_ptr <= gen_ptr + 1;
        end
    end

    assign gen_valid = gen_valid_r;
    assign gen_q     = (gen_ptr < 228) ? gen_ks[gen_ptr] : 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_unexpected: got %0h required no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 64'(out_data), 64'(e));
                    end
                end
            end
        end
    endtask

    task automatic do_cfg(input logic [63:0] k, input logic [21:0] f);
        int t = 0;
        cfg_valid = 1'b1;
        cfg_key   = k;
        cfg_frame = f;
        @(negedge clk);
        while (!cfg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        tick();
        cfg_valid = 1'b0;
        check("gen_key", gen_key, k);
        check("gen_frame", 64'(gen_frame), 64'(f));
    endtask

    task automatic send_word(input int idx, input logic [3:0] data);
        int   t = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        while (!acc && t < 400) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(golden[4 * idx +: 4] ^ data);
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got no accept for word %0d required accept", idx);
        end
    endtask

    // mode: 0 plain, 1 backpressure before word 20, 2 starvation before word 30, 3 abort at word 10
    task automatic run_burst(input logic [3:0] pat, input int mode);
        int         d0 = done_cnt;
        logic [3:0] held = '0;
        logic       aborted = 1'b0;
        do_cfg(KEY, FRAME);
        for (int w = 0; w < NW; w++) begin
            if (mode == 3 && w == 10) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                @(negedge clk);
                check("abort_out_valid", 64'(out_valid), 64'(0));
                check("abort_cfg_ready", 64'(cfg_ready), 64'(1));
                check("abort_queue_empty", 64'(exp_q.size()), 64'(0));
                tick();
                aborted = 1'b1;
                break;
            end
            if (mode == 1 && w == 20) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = pat;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (c == 0) held = out_data;
                    if (c >= 4) begin
                        check("bp_in_ready", 64'(in_ready), 64'(0));
                        check("bp_gen_stall", 64'(gen_stall), 64'(1));
                        check("bp_out_hold", 64'(out_data), 64'(held));
                    end
                    tick();
                end
                out_ready = 1'b1;
            end
            if (mode == 2 && w == 30) begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (c >= 4) check("starve_gen_stall", 64'(gen_stall), 64'(1));
                    tick();
                end
            end
            send_word(w, pat);
        end
        repeat (6) tick();
        check("done_pulses", 64'(done_cnt - d0), aborted ? 64'(0) : 64'(1));
        check("end_cfg_ready", 64'(cfg_ready), 64'(1));
        check("end_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        golden = a5_stream(KEY, FRAME);
        fork
            monitor();
        join_none

        @(negedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_gen_stall", 64'(gen_stall), 64'(1));
        check("rst_gen_load", 64'(gen_load), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        tick();
        reset = 1'b0;
        tick();

        run_burst(4'h0, 0);
        run_burst(4'hF, 0);
        run_burst(4'h0, 1);
        run_burst(4'h0, 2);
        run_burst(4'h0, 3);
        run_burst(4'h0, 0);

        do_cfg(KEY, FRAME);
        tick();
        reset = 1'b1;
        #1;
        check("wrst_cfg_ready", 64'(cfg_ready), 64'(1));
        check("wrst_in_ready", 64'(in_ready), 64'(0));
        check("wrst_out_valid", 64'(out_valid), 64'(0));
        check("wrst_out_data", 64'(out_data), 64'(0));
        check("wrst_done", 64'(done), 64'(0));
        check("wrst_gen_load", 64'(gen_load), 64'(0));
        check("wrst_gen_stall", 64'(gen_stall), 64'(1));
        check("wrst_gen_key", gen_key, 64'(0));
        check("wrst_gen_frame", 64'(gen_frame), 64'(0));
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        run_burst(4'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/a5_burst_cipher.md
Name: a5_burst_cipher

Overview:
- Consumer end of the A5 keystream generator.
- Accepts a key/frame configuration, drives the generator's load/stall controls, and packs keystream bits into DATA_W-bit words.
- XORs each word with incoming plaintext/ciphertext words over a valid/ready stream; one burst is BURST_BITS bits per frame.
- Sits between the host data path and an external keystream generator instance.

Parameters:
- DATA_W, 4, data/keystream word width; BURST_BITS % DATA_W must be 0.
- BURST_BITS, 228, keystream bits consumed per frame (114 downlink + 114 uplink).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  new key/frame offered
- cfg_ready  out  1  block idle, can accept config
- cfg_key  in  64  session key
- cfg_frame  in  22  frame number
- abort  in  1  synchronous abort of the current burst
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted this cycle when in_valid=1
- in_data  in  DATA_W  plaintext/ciphertext word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  in_data XOR keystream word
- done  out  1  one-cycle pulse after the last word of the burst is accepted
- gen_load  out  1  load strobe to generator
- gen_stall  out  1  stall to generator
- gen_key  out  64  latched key to generator
- gen_frame  out  22  latched frame to generator
- gen_q  in  1  generator keystream bit
- gen_valid  in  1  generator keystream valid

Behaviour:
- Reset values:
  - Outputs: cfg_ready=1, in_ready=0, out_valid=0, out_data=0, done=0, gen_load=0, gen_stall=1, gen_key=0, gen_frame=0.
  - Internal: state=IDLE; all counters 0.
- FSM states: IDLE, LOAD, WARMUP, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch key/frame into gen_key/gen_frame, go to LOAD.
- LOAD:
  - gen_load=1 for exactly one cycle, gen_stall=0.
  - Clear ks_cnt, word_cnt and the ks shift register. Go to WARMUP.
- WARMUP:
  - gen_stall=0.
  - Stay until gen_valid=1, then go to RUN (a capture occurs in that same cycle).
- Keystream capture:
  - capture = gen_valid && !gen_stall && state in {WARMUP, RUN}.
  - On capture: ks_word[ks_cnt] <= gen_q and ks_cnt increments. The first captured bit maps to the LSB and XORs in_data[0].
- RUN:
  - ks_full = (ks_cnt == DATA_W).
  - in_ready = ks_full && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
  - gen_stall = (ks_full && !accept) || (word_cnt == BURST_BITS/DATA_W - 1 && accept).
  - No bit is generated without being captured; stalls never drop or duplicate keystream.
- On accept:
  - out_data <= in_data ^ ks_word; out_valid <= 1; ks_cnt <= 0.
  - Refill starts in the accept cycle itself. This gives a sustained throughput of 1 word per DATA_W cycles.
  - word_cnt increments.
- Output register: out_valid clears on out_ready when no new accept occurs. out_data holds while out_valid && !out_ready.
- End of burst:
  - When the accepted word makes word_cnt reach BURST_BITS/DATA_W (57 by default), go to DONE.
  - done=1 for one cycle in DONE, then go to IDLE.
  - out_valid may still be pending in IDLE and drains normally.
  - A cfg accepted in IDLE while the last output is pending is allowed.
- abort:
  - In any non-IDLE state: go to IDLE next cycle, set gen_stall=1, clear out_valid, no done pulse.
  - Ignored in IDLE.
- Simultaneous abort and accept: abort wins; the word is not output and word_cnt is not updated.
- Reset mid-operation returns every register to its reset value immediately (asynchronous).
- Width rules:
  - ks_cnt is $clog2(DATA_W+1) bits.
  - word_cnt is $clog2(BURST_BITS/DATA_W+1) bits; it never wraps and saturates at the terminal value.

Decomposition:
- Shared package: FSM state enum, KEY_BITS=64, FRAME_BITS=22, BURST_BITS default, WORDS_PER_BURST derived constant.
- One natural sub-module: a5_ks_packer (capture logic, ks_cnt, ks_word, ks_full). The FSM, handshake and output register stay in the top.

Test Plan:
- Golden vector: key=64'h12234567_89ABCDEF, frame=22'h134, in_data=0 for all words. Expect 57 out words equal to the bench golden A5/1 keystream (LSB-first packing), done pulse exactly once, cfg_ready returns to 1.
- XOR check: same config, in_data=4'hF every word. Expect out_data equal to the bitwise complement of the scenario-1 words.
- Backpressure: hold out_ready=0 for 20 cycles mid-burst. Expect in_ready=0, gen_stall=1, out_data stable; after release, keystream continues with no skipped or repeated bits versus golden.
- Input starvation: in_valid=0 for 30 cycles after ks_full. Expect gen_stall=1 throughout and identical final output to scenario 1.
- Abort at word 10. Expect out_valid=0 next cycle, no done pulse, cfg_ready=1. A new config afterwards reproduces scenario 1 exactly.
- Assert reset during WARMUP. Expect all outputs at reset values that cycle. A new config after deassertion completes a normal burst.
